if2_fetch_queue: RTL

IF2_FETCH_QUEUE -- requirements
Module: if2_fetch_queue

---
 rtl/if2_fetch_queue_if.sv | 49 ++++
 rtl/if2_fetch_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if2_fetch_queue_if.sv
// IF2 fetch-queue bus bundle: IF1 packet, icache request/response, decode handshake.
// The DUT uses the slave modport; the environment driving it uses master.
interface if2_fetch_queue_if;
  logic        flush_i;
  logic        if2_vld_i;
  logic [31:0] if2_sip_vpc_i;
  logic [1:0]  if2_btype_i;
  logic [1:0]  if2_bm_pred_i;
  logic [31:0] if2_btb_target_i;
  logic        if2_btb_hit_i;
  logic        if2_btb_index_i;
  logic        if2_busy_o;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_gnt_i;
  logic        icache_rsp_vld_i;
  logic [63:0] icache_rsp_data_i;
  logic        icache_rsp_err_i;
  logic        dec_vld_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instr0_o;
  logic [31:0] dec_instr1_o;
  logic [1:0]  dec_slot_vld_o;
  logic        dec_pred_taken_o;
  logic [31:0] dec_btb_target_o;
  logic        dec_excp_vld_o;
  logic [3:0]  dec_excp_code_o;

  modport slave (
    input  flush_i, if2_vld_i, if2_sip_vpc_i, if2_btype_i, if2_bm_pred_i,
           if2_btb_target_i, if2_btb_hit_i, if2_btb_index_i,
           icache_gnt_i, icache_rsp_vld_i, icache_rsp_data_i, icache_rsp_err_i,
           dec_ready_i,
    output if2_busy_o, icache_req_o, icache_addr_o,
           dec_vld_o, dec_pc_o, dec_instr0_o, dec_instr1_o, dec_slot_vld_o,
           dec_pred_taken_o, dec_btb_target_o, dec_excp_vld_o, dec_excp_code_o
  );

  modport master (
    output flush_i, if2_vld_i, if2_sip_vpc_i, if2_btype_i, if2_bm_pred_i,
           if2_btb_target_i, if2_btb_hit_i, if2_btb_index_i,
           icache_gnt_i, icache_rsp_vld_i, icache_rsp_data_i, icache_rsp_err_i,
           dec_ready_i,
    input  if2_busy_o, icache_req_o, icache_addr_o,
           dec_vld_o, dec_pc_o, dec_instr0_o, dec_instr1_o, dec_slot_vld_o,
           dec_pred_taken_o, dec_btb_target_o, dec_excp_vld_o, dec_excp_code_o
  );
endinterface

// File: rtl/if2_fetch_queue.sv
// IF2 stage: issues one icache read per IF1 packet and queues fetch packets for decode.
// Optional macro IF2_BUS_ERR_EN turns icache response errors into fetch exceptions.
module if2_fetch_queue #(
  parameter int unsigned FQ_DEPTH = 4
) (
  input logic               cpu_clk_i,
  input logic               cpu_rst_ni,
  if2_fetch_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [1:0]  slot_vld;
    logic        pred_taken;
    logic [31:0] target;
`ifdef IF2_BUS_ERR_EN
    logic        excp_vld;
`endif
  } entry_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  entry_t             mem_q [FQ_DEPTH];
  entry_t             new_entry, head;

  logic [31:0] pc_q, target_q;
  logic [1:0]  btype_q, bm_pred_q;
  logic        hit_q, index_q;

  logic full, empty, accept, push, pop, busy, req;
  logic taken, slot0_vld, slot1_vld;

  assign full  = (count_q == CNT_W'(FQ_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.dec_ready_i;

  // State register
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; flush beats every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_REQ;
      S_REQ: begin
        if (bus.flush_i)           state_d = S_IDLE;
        else if (bus.icache_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.flush_i)               state_d = bus.icache_rsp_vld_i ? S_IDLE : S_DRAIN;
        else if (bus.icache_rsp_vld_i) state_d = S_IDLE;
      end
      S_DRAIN: if (bus.icache_rsp_vld_i) state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = 1'b1;
    req    = 1'b0;
    accept = 1'b0;
    push   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy   = full;
        accept = bus.if2_vld_i && !full && !bus.flush_i;
      end
      S_REQ:   req  = !bus.flush_i;
      S_WAIT:  push = bus.icache_rsp_vld_i && !bus.flush_i;
      S_DRAIN: ;
    endcase
  end

  assign bus.if2_busy_o    = busy;
  assign bus.icache_req_o  = req;
  assign bus.icache_addr_o = {pc_q[31:3], 3'b000};

  // Packet capture and queue storage carry no reset; validity lives in count_q
  always_ff @(posedge cpu_clk_i) begin
    if (accept) begin
      pc_q      <= bus.if2_sip_vpc_i;
      btype_q   <= bus.if2_btype_i;
      bm_pred_q <= bus.if2_bm_pred_i;
      target_q  <= bus.if2_btb_target_i;
      hit_q     <= bus.if2_btb_hit_i;
      index_q   <= bus.if2_btb_index_i;
    end
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  assign taken     = hit_q && ((btype_q == 2'b00) ? bm_pred_q[1] : 1'b1);
  assign slot0_vld = !pc_q[2];
  // Slot 1 is dead when the taken branch sits in a live slot 0
  assign slot1_vld = !(slot0_vld && taken && !index_q);

  always_comb begin
    new_entry            = '0;
    new_entry.pc         = pc_q;
    new_entry.instr0     = bus.icache_rsp_data_i[31:0];
    new_entry.instr1     = bus.icache_rsp_data_i[63:32];
    new_entry.slot_vld   = {slot1_vld, slot0_vld};
    new_entry.pred_taken = taken;
    new_entry.target     = target_q;
`ifdef IF2_BUS_ERR_EN
    if (bus.icache_rsp_err_i) begin
      new_entry.excp_vld = 1'b1;
      new_entry.slot_vld = 2'b00;
    end
`endif
  end

  // Queue pointers and occupancy
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (bus.flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head                 = mem_q[rd_ptr_q];
  assign bus.dec_vld_o        = !empty;
  assign bus.dec_pc_o         = head.pc;
  assign bus.dec_instr0_o     = head.instr0;
  assign bus.dec_instr1_o     = head.instr1;
  assign bus.dec_slot_vld_o   = head.slot_vld;
  assign bus.dec_pred_taken_o = head.pred_taken;
  assign bus.dec_btb_target_o = head.target;

`ifdef IF2_BUS_ERR_EN
  assign bus.dec_excp_vld_o  = !empty && head.excp_vld;
  assign bus.dec_excp_code_o = bus.dec_excp_vld_o ? 4'd1 : 4'd0;
`else
  logic unused_rsp_err;
  assign unused_rsp_err      = bus.icache_rsp_err_i;
  assign bus.dec_excp_vld_o  = 1'b0;
  assign bus.dec_excp_code_o = 4'd0;
`endif

endmodule
